ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
AHB-Lite responder. Wraps a word-organised on-chip SRAM and answers transfers issued by the team's AHB master.
- Samples the address phase and inserts a programmable number of wait states.
- Performs byte-lane-correct writes and reads.
- Optionally returns the two-cycle ERROR response.
- Sits behind the decoder/mux; memory-map slot 0 in the subsystem bench.

Parameters:
ADDR_WIDTH, 10, word-address bits; memory depth = 2**ADDR_WIDTH 32-bit words (4 KiB default).
WAIT_STATES, 1, HREADYOUT-low cycles inserted in every OKAY data phase of a NONSEQ/SEQ transfer (0..15).

Ports:
HCLK  in  1  clock; all flops rising-edge.
HRESET  in  1  asynchronous, active-high reset.
HSEL  in  1  slave select from decoder.
HADDR  in  32  byte address.
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
HWRITE  in  1  1 = write.
HSIZE  in  3  000 byte, 001 half, 010 word.
HBURST  in  3  accepted, not used for addressing (master supplies every HADDR).
HPROT  in  4  accepted, ignored.
HMASTLOCK  in  1  accepted, ignored.
HWDATA  in  32  write data, valid in data phase.
HREADY  in  1  bus-wide ready (from mux).
HREADYOUT  out  1  this slave's ready.
HRESP  out  1  0 OKAY, 1 ERROR.
HRDATA  out  32  read data.

Behaviour:
Reset and clocking:
- One clock, HCLK. HRESET is asynchronous and active-high.
- Reset values: state=S_IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, all address-phase registers 0.
- Memory contents are not reset.

Address phase:
- A transfer is accepted at a rising edge when HSEL & HREADY & HTRANS[1].
- On acceptance, register addr_q=HADDR[ADDR_WIDTH+1:0], write_q, size_q.
- IDLE/BUSY, or HSEL=0 with HREADY=1, leaves the FSM in S_IDLE: zero-wait OKAY.

FSM states: S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2.
- S_IDLE + accepted transfer:
  - WAIT_STATES>0 -> S_WAIT, counter=WAIT_STATES-1.
  - WAIT_STATES=0 -> S_DATA.
  - Error condition (feature only) -> S_ERR1.
- S_WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; when it is 0, go to S_DATA.
- S_DATA: HREADYOUT=1, HRESP=0. Transfer completes this cycle.
  - Next state is evaluated exactly as in S_IDLE, which supports back-to-back pipelined transfers.
- S_ERR1: HREADYOUT=0, HRESP=1 -> S_ERR2.
- S_ERR2: HREADYOUT=1, HRESP=1. The address phase presented here is evaluated as in S_IDLE; the master may cancel with IDLE.

Write path:
- Commit occurs at the edge ending S_DATA.
- Byte strobes, little-endian:
  - size 0: lane addr_q[1:0].
  - size 1: lanes {addr_q[1],0} and {addr_q[1],1}.
  - size 2: all four lanes.
- Only strobed bytes of HWDATA are written.

Read path:
- HRDATA = mem[addr_q word] during S_WAIT/S_DATA of a read; otherwise 32'h0.
- A read issued immediately after a write to the same word returns the new data, because the write commits before the read's data phase.

Width and range rules:
- Sizes >010 are unsupported.
- Address bits above ADDR_WIDTH+1 are range-checked (feature) or ignored (no feature).
- Reset asserted mid-transfer: immediate return to S_IDLE with reset outputs; a pending write is discarded.

Optional Feature:
Macro: AHB_SRAM_ERROR_RESP_EN
- Defined, the error conditions are:
  - HADDR[31:ADDR_WIDTH+2] != 0;
  - HSIZE > 010;
  - misaligned address (half with HADDR[0]=1; word with HADDR[1:0]!=0).
- Defined, on an error condition:
  - the transfer takes S_ERR1 -> S_ERR2 with no wait states;
  - no memory write occurs;
  - HRDATA = 0.
- Undefined: S_ERR1/S_ERR2 are not built and HRESP is tied to 0. Upper address bits wrap modulo the memory size, misaligned low bits are ignored per the strobe rules, and sizes >010 behave as word.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ);
  - HBURST codes (SINGLE..INCR16);
  - HSIZE codes;
  - HRESP codes (OKAY, ERROR);
  - the state encoding.
- Sub-module ahb_slave_mem: 2**ADDR_WIDTH x 32 array with 4-bit byte write-enable, synchronous write and asynchronous read. The top block holds the FSM, the wait counter and strobe decode.

Test Plan:
1. Reset: hold HRESET=1 for 3 cycles mid-burst -> HREADYOUT=1, HRESP=0, HRDATA=0, state S_IDLE on the same edge.
2. WAIT_STATES=2, single word write 0xDEADBEEF to 0x10, then read 0x10 -> each data phase holds HREADYOUT low for exactly 2 cycles; read returns 0xDEADBEEF.
3. Byte writes of 0x11, 0x22, 0x33, 0x44 to 0x20..0x23, then word read 0x20 -> 0x44332211. Halfword write 0xAAAA to 0x22, then read -> 0xAAAA2211.
4. WAIT_STATES=0, INCR4 back-to-back NONSEQ/SEQ writes to 0x40..0x4C, then INCR4 read -> 4 data phases with no HREADYOUT low, data matches. BUSY inserted mid-burst -> OKAY, no write.
5. With AHB_SRAM_ERROR_RESP_EN, write to 0x0000_1000 (out of range, ADDR_WIDTH=10) -> HRESP=1 with HREADYOUT 0 then 1; memory word 0 is unchanged. Without the macro, the same write lands in word 0.
6. HSEL=0 with HTRANS=NONSEQ, then HREADY=0 from another slave while NONSEQ+HSEL=1 -> no transfer accepted; HREADYOUT stays 1.

Source files
------------

// File: rtl/ahb_pkg.sv
// -----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings for the SRAM responder: transfer types, burst
// types, transfer sizes, response codes and the responder FSM state encoding.
// Also holds the little-endian byte-strobe decode used on the write path.
// -----------------------------------------------------------------------------
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011,
      HBURST_WRAP8  = 3'b100,
      HBURST_INCR8  = 3'b101,
      HBURST_WRAP16 = 3'b110,
      HBURST_INCR16 = 3'b111
   } hburst_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'b000,
      HSIZE_HALF = 3'b001,
      HSIZE_WORD = 3'b010
   } hsize_e;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   // Little-endian lane enables. Any size above a word is treated as a word.
   function automatic logic [3:0] byte_strobe(input logic [1:0] lo, input logic [2:0] size);
      case (size)
         HSIZE_BYTE: return 4'b0001 << lo;
         HSIZE_HALF: return lo[1] ? 4'b1100 : 4'b0011;
         default:    return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// -----------------------------------------------------------------------------
// ahb_slave_mem
// Word-organised SRAM, 2**ADDR_WIDTH x 32 bits, with per-byte write enables.
// Synchronous write, asynchronous (combinational) read, single address port.
//
// Ports:
//   HCLK   in   1            write clock
//   we     in   1            write enable
//   be     in   4            byte-lane enables (bit i -> wdata[8i+7:8i])
//   addr   in   ADDR_WIDTH   word address, shared by read and write
//   wdata  in   32           write data
//   rdata  out  32           read data for addr
// -----------------------------------------------------------------------------
module ahb_slave_mem #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  HCLK,
   input  logic                  we,
   input  logic [3:0]            be,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [0:(1 << ADDR_WIDTH)-1];

   // NOTE: the array has no reset; clearing a RAM needs a sweep, and contents
   // are undefined after power-up anyway.
   always_ff @(posedge HCLK) begin
      for (int i = 0; i < 4; i++) begin
         if (we && be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// -----------------------------------------------------------------------------
// ahb_sram_slave
// AHB-Lite responder in front of a word-organised on-chip SRAM. Samples the
// address phase, inserts WAIT_STATES wait cycles into every OKAY data phase,
// and performs byte-lane-correct writes and reads.
//
// Build option: define AHB_SRAM_ERROR_RESP_EN to return a two-cycle ERROR
// response for out-of-range addresses, sizes above a word and misaligned
// half/word transfers. Without it HRESP is tied to OKAY, the upper address
// bits wrap and illegal sizes act as word transfers.
//
// Ports:
//   HCLK       in   1    clock, rising edge
//   HRESET     in   1    asynchronous active-high reset
//   HSEL       in   1    slave select
//   HADDR      in   32   byte address
//   HTRANS     in   2    transfer type
//   HWRITE     in   1    1 = write
//   HSIZE      in   3    transfer size
//   HBURST     in   3    burst type (not used)
//   HPROT      in   4    protection (not used)
//   HMASTLOCK  in   1    lock (not used)
//   HWDATA     in   32   write data (data phase)
//   HREADY     in   1    bus-wide ready
//   HREADYOUT  out  1    this slave's ready
//   HRESP      out  1    response, 0 OKAY / 1 ERROR
//   HRDATA     out  32   read data
// -----------------------------------------------------------------------------
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic        HMASTLOCK,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam int         AW        = ADDR_WIDTH + 2;  // byte-address bits kept
   localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t          state_q, state_d, phase_next;
   logic [3:0]      wait_q, wait_d;
   logic [AW-1:0]   addr_q;
   logic            write_q;
   logic [2:0]      size_q;
   logic            accept;
   logic            mem_we;
   logic [3:0]      mem_be;
   logic [31:0]     mem_rdata;
   logic            unused_ok;

   // NONSEQ and SEQ both have HTRANS[1] set; IDLE and BUSY never start a transfer.
   assign accept = HSEL & HREADY & HTRANS[1];

`ifdef AHB_SRAM_ERROR_RESP_EN
   logic addr_err;
   assign addr_err = (HADDR[31:AW] != '0)
                   | (HSIZE > HSIZE_WORD)
                   | ((HSIZE == HSIZE_HALF) & HADDR[0])
                   | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (accept) begin
            addr_q  <= HADDR[AW-1:0];
            write_q <= HWRITE;
            size_q  <= HSIZE;
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      phase_next = S_IDLE;
      state_d    = state_q;
      wait_d     = wait_q;
      HREADYOUT  = 1'b1;
      HRESP      = HRESP_OKAY;

      // Where the address phase currently on the bus would take us.
      if (accept) begin
`ifdef AHB_SRAM_ERROR_RESP_EN
         if (addr_err)              phase_next = S_ERR1;
         else
`endif
         if (WAIT_STATES > 0)       phase_next = S_WAIT;
         else                       phase_next = S_DATA;
      end

      case (state_q)
         // Idle and the last data cycle both accept a new address phase,
         // which gives back-to-back pipelined transfers.
         S_IDLE, S_DATA: begin
            state_d = phase_next;
            wait_d  = WAIT_INIT;
         end
         S_WAIT: begin
            HREADYOUT = 1'b0;
            if (wait_q == 4'd0) state_d = S_DATA;
            else                wait_d  = wait_q - 4'd1;
         end
`ifdef AHB_SRAM_ERROR_RESP_EN
         S_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
            state_d   = S_ERR2;
         end
         S_ERR2: begin
            HRESP   = HRESP_ERROR;
            state_d = phase_next;
            wait_d  = WAIT_INIT;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Writes commit on the edge that ends S_DATA; a following read of the same
   // word therefore sees the new data in its own data phase.
   assign mem_we = (state_q == S_DATA) & write_q;
   assign mem_be = byte_strobe(addr_q[1:0], size_q);

   assign HRDATA = (((state_q == S_WAIT) || (state_q == S_DATA)) && !write_q) ? mem_rdata : 32'h0;

   ahb_slave_mem #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_mem (
      .HCLK  (HCLK),
      .we    (mem_we),
      .be    (mem_be),
      .addr  (addr_q[AW-1:2]),
      .wdata (HWDATA),
      .rdata (mem_rdata)
   );

   // Inputs the protocol delivers but this responder deliberately ignores.
   assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR[31:AW]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_ahb_sram_slave
// Directed bench for ahb_sram_slave. Two responders share one bus: u_ws2
// (WAIT_STATES=2) and u_ws0 (WAIT_STATES=0), each with its own HSEL; a small
// mux returns the data-phase owner's HREADYOUT as HREADY. Inputs change on
// the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_ahb_sram_slave;
   import ahb_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        hsel_a = 1'b0;     // selects u_ws2
   logic        hsel_b = 1'b0;     // selects u_ws0
   logic [31:0] HADDR = '0;
   logic [1:0]  HTRANS = HTRANS_IDLE;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = HSIZE_WORD;
   logic [2:0]  HBURST = HBURST_SINGLE;
   logic [3:0]  HPROT = 4'b0011;
   logic        HMASTLOCK = 1'b0;
   logic [31:0] HWDATA = '0;
   logic        HREADY;
   logic        rdy_a, rdy_b, resp_a, resp_b;
   logic [31:0] rdata_a, rdata_b;
   logic        hready_ext_low = 1'b0;   // another slave stalling the bus
   logic        dp_b = 1'b0;             // data phase belongs to u_ws0

   int n_checks = 0;
   int n_fail   = 0;

   always #5 HCLK = ~HCLK;

   assign HREADY = !hready_ext_low && (dp_b ? rdy_b : rdy_a);

   always @(posedge HCLK or posedge HRESET) begin
      if (HRESET)      dp_b <= 1'b0;
      else if (HREADY) dp_b <= hsel_b;
   end

   ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_ws2 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel_a), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(rdy_a), .HRESP(resp_a), .HRDATA(rdata_a)
   );

   ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel_b), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(rdy_b), .HRESP(resp_b), .HRDATA(rdata_b)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // One non-pipelined transfer: address phase, then data phase with the bus
   // idle. Returns read data, wait cycles, and HRESP in the first and last
   // data-phase cycles.
   task automatic xfer(input logic b, input logic wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int waits,
                       output logic resp_first, output logic resp_last);
      @(negedge HCLK);
      hsel_a = ~b; hsel_b = b;
      HADDR = addr; HTRANS = HTRANS_NONSEQ; HWRITE = wr; HSIZE = size;
      @(negedge HCLK);
      hsel_a = 1'b0; hsel_b = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = wdata;
      waits = 0;
      resp_first = dp_b ? resp_b : resp_a;
      while (!HREADY && waits < 40) begin
         waits++;
         @(negedge HCLK);
      end
      rdata     = dp_b ? rdata_b : rdata_a;
      resp_last = dp_b ? resp_b : resp_a;
   endtask

   task automatic wr(input logic b, input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
      logic [31:0] rd; int w; logic r0, r1;
      xfer(b, 1'b1, addr, size, data, rd, w, r0, r1);
   endtask

   task automatic rd_check(input string tag, input logic b, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] rd; int w; logic r0, r1;
      xfer(b, 1'b0, addr, HSIZE_WORD, 32'h0, rd, w, r0, r1);
      check(tag, rd, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd;
      int          w, lows;
      logic        r0, r1;
      logic [31:0] burst_d [4];

      burst_d = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};

      // ---- Power-on reset values -------------------------------------------
      #1;
      check("por_ready_ws2", rdy_a, 1);
      check("por_resp_ws2",  resp_a, 0);
      check("por_rdata_ws2", rdata_a, 32'h0);
      check("por_ready_ws0", rdy_b, 1);
      repeat (2) @(negedge HCLK);
      HRESET = 1'b0;

      // ---- WAIT_STATES=2 word write then read -------------------------------
      xfer(1'b0, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, rd, w, r0, r1);
      check("ws2_wr_waits", w, 2);
      check("ws2_wr_resp", r1, 0);
      xfer(1'b0, 1'b0, 32'h10, HSIZE_WORD, 32'h0, rd, w, r0, r1);
      check("ws2_rd_waits", w, 2);
      check("ws2_rd_data", rd, 32'hDEADBEEF);

      // ---- Byte and halfword lanes ------------------------------------------
      wr(1'b0, 32'h20, HSIZE_BYTE, 32'h1111_1111);
      wr(1'b0, 32'h21, HSIZE_BYTE, 32'h2222_2222);
      wr(1'b0, 32'h22, HSIZE_BYTE, 32'h3333_3333);
      wr(1'b0, 32'h23, HSIZE_BYTE, 32'h4444_4444);
      rd_check("byte_lanes", 1'b0, 32'h20, 32'h44332211);
      wr(1'b0, 32'h22, HSIZE_HALF, 32'hAAAA_AAAA);
      rd_check("half_upper", 1'b0, 32'h20, 32'hAAAA2211);

      // ---- WAIT_STATES=0 INCR4 write and read bursts ------------------------
      @(negedge HCLK);
      hsel_b = 1'b1; HADDR = 32'h40; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1;
      HSIZE = HSIZE_WORD; HBURST = HBURST_INCR4;
      lows = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge HCLK);
         if (!HREADY) lows++;
         HWDATA = burst_d[i];
         if (i < 3) begin HADDR = 32'h40 + 32'(4*(i+1)); HTRANS = HTRANS_SEQ; end
         else begin hsel_b = 1'b0; HTRANS = HTRANS_IDLE; end
      end
      check("incr4_wr_no_wait", lows, 0);

      @(negedge HCLK);
      hsel_b = 1'b1; HADDR = 32'h40; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0;
      lows = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge HCLK);
         if (!HREADY) lows++;
         check($sformatf("incr4_rd_beat%0d", i), rdata_b, burst_d[i]);
         if (i < 3) begin HADDR = 32'h40 + 32'(4*(i+1)); HTRANS = HTRANS_SEQ; end
         else begin hsel_b = 1'b0; HTRANS = HTRANS_IDLE; HBURST = HBURST_SINGLE; end
      end
      check("incr4_rd_no_wait", lows, 0);

      // ---- Write immediately followed by read of the same word -------------
      @(negedge HCLK);
      hsel_b = 1'b1; HADDR = 32'h80; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1;
      @(negedge HCLK);
      HWDATA = 32'h600DCAFE; HWRITE = 1'b0;
      @(negedge HCLK);
      check("raw_same_word", rdata_b, 32'h600DCAFE);
      hsel_b = 1'b0; HTRANS = HTRANS_IDLE;

      // ---- BUSY in the middle of a burst: OKAY, no write --------------------
      wr(1'b1, 32'h58, HSIZE_WORD, 32'h5A5A5A5A);
      @(negedge HCLK);
      hsel_b = 1'b1; HADDR = 32'h50; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HBURST = HBURST_INCR;
      @(negedge HCLK);
      HWDATA = 32'h1111_1111; HTRANS = HTRANS_BUSY; HADDR = 32'h58;
      @(negedge HCLK);
      check("busy_ready", HREADY, 1);
      check("busy_resp", resp_b, 0);
      HWDATA = 32'hBAD0BAD0; HTRANS = HTRANS_SEQ; HADDR = 32'h54;
      @(negedge HCLK);
      HWDATA = 32'h2222_2222; HTRANS = HTRANS_IDLE; hsel_b = 1'b0; HBURST = HBURST_SINGLE;
      rd_check("busy_beat0", 1'b1, 32'h50, 32'h11111111);
      rd_check("busy_beat1", 1'b1, 32'h54, 32'h22222222);
      rd_check("busy_no_write", 1'b1, 32'h58, 32'h5A5A5A5A);

      // ---- Out-of-range / misaligned transfers -------------------------------
      wr(1'b0, 32'h0, HSIZE_WORD, 32'h01234567);
      xfer(1'b0, 1'b1, 32'h0000_1000, HSIZE_WORD, 32'hFFFF_FFFF, rd, w, r0, r1);
`ifdef AHB_SRAM_ERROR_RESP_EN
      check("oor_wr_cycles", w, 1);
      check("oor_resp_first", r0, 1);
      check("oor_resp_last", r1, 1);
      rd_check("oor_word0_kept", 1'b0, 32'h0, 32'h01234567);
      xfer(1'b0, 1'b0, 32'h0000_1000, HSIZE_WORD, 32'h0, rd, w, r0, r1);
      check("oor_rd_data", rd, 32'h0);
      check("oor_rd_resp", r1, 1);
      xfer(1'b0, 1'b1, 32'h21, HSIZE_HALF, 32'h5555_5555, rd, w, r0, r1);
      check("misaligned_half_resp", r1, 1);
      rd_check("misaligned_no_write", 1'b0, 32'h20, 32'hAAAA2211);
`else
      check("oor_wr_waits", w, 2);
      check("oor_resp_first", r0, 0);
      check("oor_resp_last", r1, 0);
      rd_check("oor_wraps_word0", 1'b0, 32'h0, 32'hFFFFFFFF);
`endif

      // ---- Unselected and stalled address phases -----------------------------
      wr(1'b0, 32'h70, HSIZE_WORD, 32'h0BADF00D);
      @(negedge HCLK);
      hsel_a = 1'b0; hsel_b = 1'b0; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1;
      HADDR = 32'h70; HWDATA = 32'hFFFF_FFFF;
      @(negedge HCLK);
      check("unsel_ready", rdy_a, 1);
      hsel_a = 1'b1; hready_ext_low = 1'b1;
      @(negedge HCLK);
      check("stalled_ready_hold", rdy_a, 1);
      hsel_a = 1'b0; HTRANS = HTRANS_IDLE; hready_ext_low = 1'b0;
      @(negedge HCLK);
      check("stalled_not_taken", rdy_a, 1);
      rd_check("stalled_no_write", 1'b0, 32'h70, 32'h0BADF00D);

      // ---- Reset asserted during a read wait and a write wait ----------------
      wr(1'b0, 32'h60, HSIZE_WORD, 32'hCAFEF00D);
      @(negedge HCLK);
      hsel_a = 1'b1; HADDR = 32'h60; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0;
      @(negedge HCLK);
      hsel_a = 1'b0; HTRANS = HTRANS_IDLE;
      check("rd_wait_ready", rdy_a, 0);
      check("rd_wait_data", rdata_a, 32'hCAFEF00D);
      HRESET = 1'b1;
      #1;
      check("rst_rd_ready", rdy_a, 1);
      check("rst_rd_resp", resp_a, 0);
      check("rst_rd_rdata", rdata_a, 32'h0);
      repeat (3) @(negedge HCLK);
      check("rst_hold_ready", rdy_a, 1);
      HRESET = 1'b0;

      @(negedge HCLK);
      hsel_a = 1'b1; HADDR = 32'h60; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1;
      @(negedge HCLK);
      hsel_a = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 32'h12345678;
      check("wr_wait_ready", rdy_a, 0);
      HRESET = 1'b1;
      #1;
      check("rst_wr_ready", rdy_a, 1);
      repeat (3) @(negedge HCLK);
      HRESET = 1'b0;
      rd_check("rst_write_dropped", 1'b0, 32'h60, 32'hCAFEF00D);

      repeat (2) @(negedge HCLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
